// File: rtl/timer_irq.sv
// timer_irq: bus-programmable countdown timer that raises a maskable interrupt on expiry,
// with one-shot and auto-reload modes and an optional power-of-two prescaler.
module timer_irq #(
    parameter int PRESCALE_BITS = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);
    localparam int PW = (PRESCALE_BITS > 0) ? PRESCALE_BITS : 1;

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_ctrl;
    logic [31:0]   r_preset, r_count;
    logic          r_pend;
    logic [PW-1:0] r_pre;
    logic          w_tick, w_ack, w_wr_ctrl, w_wr_preset, w_reload, w_en;

    assign w_en        = r_ctrl[0];
    assign w_reload    = r_ctrl[2:1] == 2'b01;
    assign w_wr_ctrl   = We && Addr == 2'd0;
    assign w_wr_preset = We && Addr == 2'd1;
    assign w_ack       = w_wr_ctrl || w_wr_preset;
    assign w_tick      = (PRESCALE_BITS == 0) || (&r_pre);
    assign IRQ         = r_pend & r_ctrl[3];

    always_comb begin
        Dout = Addr == 2'd0 ? {28'b0, r_ctrl} :
               Addr == 2'd1 ? r_preset :
               Addr == 2'd2 ? r_count : 32'd0;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: w_next = w_en ? LOAD : IDLE;
            LOAD: w_next = CNT;
            CNT:  w_next = !w_en ? IDLE : (w_tick && r_count <= 32'd1) ? INT : CNT;
            INT:  w_next = w_reload ? LOAD : IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_ctrl   <= '0;
            r_preset <= '0;
            r_count  <= '0;
            r_pend   <= 1'b0;
            r_pre    <= '0;
        end else begin
            r_state <= w_next;
            // a bus write to CTRL takes precedence over the one-shot self-disable
            if (w_wr_ctrl)
                r_ctrl <= Din[3:0];
            else if (r_state == INT && !w_reload)
                r_ctrl[0] <= 1'b0;
            if (w_wr_preset)
                r_preset <= Din;
            if (r_state == LOAD)
                r_count <= r_preset;
            else if (r_state == CNT && w_en && w_tick && r_count != 32'd0)
                r_count <= r_count - 32'd1;
            if (r_state == LOAD)
                r_pre <= '0;
            else if (r_state == CNT && w_en)
                r_pre <= r_pre + PW'(1);
            if (w_ack)
                r_pend <= 1'b0;
            else if (r_state == INT)
                r_pend <= 1'b1;
            else if (r_state == LOAD && w_reload)
                r_pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_timer_irq.sv
// tb_timer_irq: randomized and directed checks of timer_irq against an arithmetic model
// of when COUNT holds which value and when IRQ is asserted after an enabling write.
module tb_timer_irq;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [1:0]  Addr = 2'd0;
    logic        We = 1'b0;
    logic [31:0] Din = 32'd0;
    logic [31:0] Dout;
    logic        IRQ;
    int passed = 0;
    int total = 0;

    timer_irq #(.PRESCALE_BITS(0)) dut (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .We(We), .Din(Din), .Dout(Dout), .IRQ(IRQ)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        We = 1'b1; Addr = a; Din = d;
        tick();
        We = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = Dout;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
    endtask

    // COUNT k edges after the enabling write (timer started from reset state)
    function automatic logic [31:0] m_count(int n, bit ar, int k);
        int p, j;
        if (k < 2) return 32'd0;
        if (!ar) return (k - 2 >= n) ? 32'd0 : 32'(n - (k - 2));
        p = (n > 1 ? n : 1) + 2;
        j = (k - 2) % p;
        return (j >= n) ? 32'd0 : 32'(n - j);
    endfunction

    // expiry completes max(n,1)+3 edges after enable; auto-reload repeats every max(n,1)+2
    function automatic logic m_irq(int n, bit ar, bit im, int k);
        int m;
        m = n > 1 ? n : 1;
        if (!im) return 1'b0;
        if (!ar) return k >= m + 3;
        return k >= 2 && (k - 2) % (m + 2) == m + 1;
    endfunction

    task automatic run_exp(input int n, input logic [1:0] mode, input bit im);
        logic [31:0] d;
        bit ar;
        int m, kmax;
        ar = mode == 2'b01;
        m = n > 1 ? n : 1;
        kmax = ar ? 4 * (m + 2) + 3 : m + 6;
        do_reset();
        wr(2'd1, 32'(n));
        wr(2'd0, {28'd0, im, mode, 1'b1});
        for (int k = 1; k <= kmax; k++) begin
            tick();
            rd(2'd2, d);
            chk($sformatf("count n=%0d mode=%0d k=%0d", n, mode, k), d, m_count(n, ar, k));
            chk($sformatf("irq n=%0d mode=%0d im=%0d k=%0d", n, mode, im, k), 32'(IRQ), 32'(m_irq(n, ar, im, k)));
        end
        if (!ar) begin
            rd(2'd0, d);
            chk("ctrl after one-shot", d, {28'd0, im, mode, 1'b0});
            wr(2'd0, {28'd0, im, mode, 1'b0});
            chk("irq after ctrl ack", 32'(IRQ), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] d;
        // reset mid-count
        do_reset();
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h9);
        repeat (8) tick();
        rd(2'd2, d);
        chk("count before reset", d, 32'd94);
        Reset = 1'b0;
        tick();
        chk("irq in reset", 32'(IRQ), 32'd0);
        tick();
        Reset = 1'b1;
        rd(2'd2, d); chk("count after reset", d, 32'd0);
        rd(2'd0, d); chk("ctrl after reset", d, 32'd0);
        rd(2'd1, d); chk("preset after reset", d, 32'd0);
        tick();
        rd(2'd2, d); chk("count stays 0", d, 32'd0);
        // directed one-shot, auto-reload, masked, zero preset
        run_exp(3, 2'b00, 1'b1);
        run_exp(3, 2'b01, 1'b1);
        run_exp(0, 2'b00, 1'b1);
        run_exp(0, 2'b01, 1'b1);
        run_exp(2, 2'b00, 1'b0);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h8);
        repeat (3) begin
            tick();
            chk("masked then acked irq", 32'(IRQ), 32'd0);
        end
        // randomized configurations
        repeat (10) run_exp(int'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        // pause and resume
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        repeat (6) tick();
        rd(2'd2, d); chk("pause count6", d, 32'd6);
        wr(2'd0, 32'h8);
        repeat (4) tick();
        rd(2'd2, d); chk("paused count", d, 32'd5);
        wr(2'd1, 32'd7);
        rd(2'd2, d); chk("preset write no effect", d, 32'd5);
        wr(2'd0, 32'h9);
        tick();
        tick();
        rd(2'd2, d); chk("resume reload", d, 32'd7);
        // re-writing Enable while counting does not restart
        wr(2'd0, 32'h9);
        rd(2'd2, d); chk("no restart", d, 32'd6);
        // Addr2/3 writes ignored, Addr3 reads 0
        wr(2'd2, 32'h55);
        wr(2'd3, 32'hAA);
        rd(2'd3, d); chk("addr3 read", d, 32'd0);
        rd(2'd1, d); chk("preset untouched", d, 32'd7);
        rd(2'd0, d); chk("ctrl untouched", d, 32'h9);
        rd(2'd2, d); chk("count after ignored wr", d, 32'd4);
        // CTRL write on the INT cycle: bus wins and acks
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        repeat (5) tick();
        wr(2'd0, 32'h9);
        rd(2'd0, d); chk("ctrl bus wins", d, 32'h9);
        chk("ack wins over int", 32'(IRQ), 32'd0);
        tick();
        tick();
        rd(2'd2, d); chk("restart after int", d, 32'd3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
